seq_match_logger: RTL and testbench
===================================

# seq_match_logger

Downstream consumer of the `mealy10010` sequence detector's match output `w`. It samples `w` on every rising clock edge and stamps each match with a free-running cycle timestamp. The timestamps are buffered in a small FIFO that a host or bench drains with a simple valid/pop handshake. It also keeps a saturating total-match counter and a sticky overflow flag, so long detector runs can be checked without watching `w` cycle by cycle.

## Interface
Parameters:
- `TS_W`, 16: timestamp width in bits; the timestamp counter wraps modulo 2^TS_W.
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.
- `CNT_W`, 8: width of the total-match counter.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: logging enable; while low, `w` is ignored and the timestamp keeps running.
- `w`  in  1: detector match output (Mealy, may glitch mid-cycle); only its value at the rising edge counts.
- `rd`  in  1: pop request for the FIFO head.
- `valid`  out  1: FIFO non-empty; `ts_out` is meaningful only while high.
- `ts_out`  out  TS_W: timestamp at the FIFO head.
- `count`  out  CNT_W: total accepted matches, saturating.
- `overflow`  out  1: sticky; set when a match is dropped because the FIFO is full.

## Operation
- Timestamp register `ts`:
  - Reset to 0.
  - Increments by 1 every cycle regardless of `en`.
  - Wraps from 2^TS_W−1 to 0.
- Match event: `ev = en & w` sampled at the edge; see Configuration for edge mode.
- Push: on `ev`, write the current `ts` (value before this edge's increment).
- Pop: on `rd & valid`, advance the read pointer. `rd` while empty is ignored, with no state change.
- Push and pop in the same cycle:
  - Both happen and occupancy is unchanged.
  - When full, push+pop is legal: no drop, `overflow` untouched.
  - When empty, push+pop is treated as push only, because `valid` is low at that edge.
- Push when full without pop:
  - The event is dropped and FIFO contents are unchanged.
  - `overflow` is set to 1 and stays 1 until `rst`.
  - `count` still increments, so `count` reflects all accepted matches, including dropped ones.
- `count` increments on every `ev` and saturates at 2^CNT_W−1.
- Reset values: `valid`=0, `ts_out`=0, `count`=0, `overflow`=0, `ts`=0, both pointers 0.
- Reset asserted mid-operation discards all FIFO contents at that edge. A simultaneous `ev` or `rd` is ignored.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `w`/`rd` to any output.
- Event at edge k:
  - `valid`=1 and `count` updated in the cycle after edge k.
  - `ts_out` equals the `ts` value present before edge k (if the FIFO was empty).
- Pop at edge k: the next entry (or `valid`=0) appears after edge k.
- Maximum sustained rate is one push and one pop per cycle.

## Configuration
- `SEQ_LOG_EDGE_EN` defined:
  - `ev = en & w & ~w_q`, where `w_q` is `w` registered (reset 0).
  - A `w` held high for N consecutive cycles logs one event.
- `SEQ_LOG_EDGE_EN` undefined:
  - Every cycle with `en & w` at the edge logs one event.
  - `w` high for 3 cycles logs 3 events.

## Structure
- Package `seq_log_pkg`:
  - Default `TS_W`/`DEPTH`/`CNT_W` localparams.
  - `ts_t` typedef (logic [TS_W-1:0]).
  - `ptr_w = $clog2(DEPTH)`.
- Sub-module `sync_fifo`:
  - Parameterized width/depth.
  - Pointers with an extra wrap bit for full/empty detection.
  - Push/pop/full/empty ports.
- Timestamp counter, event logic, `count` and `overflow` stay in the top.

## Test plan
Clock period 20 ns; reset held high for 2 edges, then low.
- Single match: `en`=1, `w`=1 at the edge where `ts`=5 → next cycle `valid`=1, `ts_out`=5, `count`=1; `rd` for one edge → `valid`=0.
- Feed `j` = 1,0,0,1,0,0,1,0 through `mealy10010` into this block (overlapping detection) → two entries with timestamps 3 cycles apart, `count`=2, `overflow`=0.
- Five events at `ts`=10,12,14,16,18 with no `rd`, `DEPTH`=4 → FIFO holds 10,12,14,16; `overflow`=1; `count`=5.
- Full FIFO, push at `ts`=20 and `rd` in the same edge → head advances to 12, tail gets 20, `overflow` unchanged.
- `w` high for 3 cycles → 3 entries and `count`=3 without the macro; 1 entry and `count`=1 with `SEQ_LOG_EDGE_EN`.
- `CNT_W`=4, 17 events with `rd` held high → `count` stops at 15; `rst` mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/seq_log_pkg.sv
// Shared defaults and types for the sequence-match logger.
package seq_log_pkg;

   localparam int DEF_TS_W  = 16;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_CNT_W = 8;

   typedef logic [DEF_TS_W-1:0] ts_t;

   localparam int ptr_w = $clog2(DEF_DEPTH);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted only when a pop frees a slot at the same edge.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) &&
                    (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign do_pop  = pop & ~empty & ~rst;
   assign do_push = push & (~full | do_pop) & ~rst;

   // Head reads as zero while empty so the output is defined out of reset.
   assign dout = empty ? '0 : mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/seq_match_logger.sv
// Timestamps detector matches into a FIFO, with saturating count and sticky
// overflow. Define SEQ_LOG_EDGE_EN to log only rising edges of w.
module seq_match_logger
   import seq_log_pkg::*;
#(
   parameter int TS_W  = DEF_TS_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             w,
   input  logic             rd,
   output logic             valid,
   output logic [TS_W-1:0]  ts_out,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   logic [TS_W-1:0] ts;
   logic            ev;
   logic            full;
   logic            empty;
   logic            pop_ok;

   // Free-running timestamp; each entry carries the pre-increment value.
   always_ff @(posedge clk) begin
      if (rst) ts <= '0;
      else     ts <= ts + 1'b1;
   end

`ifdef SEQ_LOG_EDGE_EN
   logic w_q;

   always_ff @(posedge clk) begin
      if (rst) w_q <= 1'b0;
      else     w_q <= w;
   end

   assign ev = en & w & ~w_q;
`else
   assign ev = en & w;
`endif

   // Handshake: ts_out is the head entry whenever valid is high; a high rd at
   // an edge where valid is high consumes it, and rd while valid is low is a
   // no-op.
   assign valid  = ~empty;
   assign pop_ok = rd & valid;

   sync_fifo #(
      .WIDTH (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ev),
      .din   (ts),
      .pop   (rd),
      .dout  (ts_out),
      .full  (full),
      .empty (empty)
   );

   // Dropped events still count, so count reflects every accepted match.
   always_ff @(posedge clk) begin
      if (rst)                               count <= '0;
      else if (ev && count != {CNT_W{1'b1}}) count <= count + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)                        overflow <= 1'b0;
      else if (ev && full && !pop_ok) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_seq_match_logger.sv
// Bench for seq_match_logger: directed table, corner sequences and random
// traffic against a queue-based reference model; two instances (default and
// narrow TS_W/CNT_W) share the same stimulus.
module tb_seq_match_logger;
   import seq_log_pkg::*;

   localparam int TS_W     = DEF_TS_W;
   localparam int DEPTH    = DEF_DEPTH;
   localparam int CNT_W    = DEF_CNT_W;
   localparam int SM_TS_W  = 4;
   localparam int SM_CNT_W = 4;

`ifdef SEQ_LOG_EDGE_EN
   localparam bit EDGE_MODE = 1'b1;
`else
   localparam bit EDGE_MODE = 1'b0;
`endif

   logic                clk;
   logic                rst;
   logic                en;
   logic                w;
   logic                rd;
   logic                valid;
   ts_t                 ts_out;
   logic [CNT_W-1:0]    count;
   logic                overflow;
   logic                valid_s;
   logic [SM_TS_W-1:0]  ts_out_s;
   logic [SM_CNT_W-1:0] count_s;
   logic                overflow_s;

   seq_match_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .w(w), .rd(rd),
      .valid(valid), .ts_out(ts_out), .count(count), .overflow(overflow)
   );

   seq_match_logger #(.TS_W(SM_TS_W), .DEPTH(DEPTH), .CNT_W(SM_CNT_W)) dut_s (
      .clk(clk), .rst(rst), .en(en), .w(w), .rd(rd),
      .valid(valid_s), .ts_out(ts_out_s), .count(count_s), .overflow(overflow_s)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // ---------------- reference model ----------------
   int m_cyc;
   int m_total;
   bit m_ovf;
   bit m_wq;
   int m_q[$];

   task automatic model_update(input bit r, input bit e, input bit ww, input bit rr);
      bit ev;
      bit was_full;
      bit popped;
      if (r) begin
         m_cyc = 0; m_total = 0; m_ovf = 0; m_wq = 0;
         m_q.delete();
      end else begin
         ev       = e && ww && (!EDGE_MODE || !m_wq);
         was_full = (m_q.size() == DEPTH);
         popped   = rr && (m_q.size() > 0);
         if (popped) void'(m_q.pop_front());
         if (ev) begin
            m_total++;
            if (!was_full || popped) m_q.push_back(m_cyc);
            else                     m_ovf = 1;
         end
         m_wq = ww;
         m_cyc++;
      end
   endtask

   // ---------------- scoreboard ----------------
   int n_vec;
   int n_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic compare_model(input int idx);
      bit ev_valid;
      ev_valid = (m_q.size() > 0);
      check($sformatf("rnd%0d_valid", idx), {31'd0, valid}, {31'd0, ev_valid});
      check($sformatf("rnd%0d_count", idx), {24'd0, count},
            (m_total > 255) ? 32'd255 : m_total);
      check($sformatf("rnd%0d_ovf", idx), {31'd0, overflow}, {31'd0, m_ovf});
      check($sformatf("rnd%0d_valid_s", idx), {31'd0, valid_s}, {31'd0, ev_valid});
      check($sformatf("rnd%0d_count_s", idx), {28'd0, count_s},
            (m_total > 15) ? 32'd15 : m_total);
      check($sformatf("rnd%0d_ovf_s", idx), {31'd0, overflow_s}, {31'd0, m_ovf});
      if (ev_valid) begin
         check($sformatf("rnd%0d_ts", idx), {16'd0, ts_out}, m_q[0] % 65536);
         check($sformatf("rnd%0d_ts_s", idx), {28'd0, ts_out_s}, m_q[0] % 16);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit r, input bit e, input bit ww, input bit rr);
      rst = r; en = e; w = ww; rd = rr;
      @(posedge clk);
      model_update(r, e, ww, rr);
      @(negedge clk);
   endtask

   task automatic reset_dut();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
   endtask

   task automatic pop_check(input string name, input int exp_ts);
      check({name, "_valid"}, {31'd0, valid}, 32'd1);
      check({name, "_ts"}, {16'd0, ts_out}, exp_ts);
      step(0, 0, 0, 1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_valid"}, {31'd0, valid}, 32'd0);
      check({name, "_ts"}, {16'd0, ts_out}, 32'd0);
      check({name, "_count"}, {24'd0, count}, 32'd0);
      check({name, "_ovf"}, {31'd0, overflow}, 32'd0);
      check({name, "_valid_s"}, {31'd0, valid_s}, 32'd0);
      check({name, "_ts_s"}, {28'd0, ts_out_s}, 32'd0);
      check({name, "_count_s"}, {28'd0, count_s}, 32'd0);
      check({name, "_ovf_s"}, {31'd0, overflow_s}, 32'd0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit r; bit e; bit w; bit rd;
      bit v; int ts; int cnt; bit ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit r, bit e, bit ww, bit rr, bit v, int ts, int cnt, bit ovf);
      vec_t t;
      t.r = r; t.e = e; t.w = ww; t.rd = rr;
      t.v = v; t.ts = ts; t.cnt = cnt; t.ovf = ovf;
      tbl.push_back(t);
   endfunction

   initial begin
      bit jbits[8];
      logic [4:0] hist;
      bit wj;
      int rd_pct;

      n_vec = 0; n_err = 0;
      m_cyc = 0; m_total = 0; m_ovf = 0; m_wq = 0;
      rst = 1; en = 0; w = 0; rd = 0;

      // Single match at ts=5, then pop.
      for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 5, 1, 0);
      add(0, 0, 0, 1, 0, 0, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      // Five events into a four-deep FIFO at ts=10..18.
      for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 10, 1, 0);
      add(0, 1, 0, 0, 1, 10, 1, 0);
      add(0, 1, 1, 0, 1, 10, 2, 0);
      add(0, 1, 0, 0, 1, 10, 2, 0);
      add(0, 1, 1, 0, 1, 10, 3, 0);
      add(0, 1, 0, 0, 1, 10, 3, 0);
      add(0, 1, 1, 0, 1, 10, 4, 0);
      add(0, 1, 0, 0, 1, 10, 4, 0);
      add(0, 1, 1, 0, 1, 10, 5, 1);
      add(0, 1, 0, 0, 1, 10, 5, 1);
      // Push+pop while full at ts=20, then drain.
      add(0, 1, 1, 1, 1, 12, 6, 1);
      add(0, 1, 0, 1, 1, 14, 6, 1);
      add(0, 1, 0, 1, 1, 16, 6, 1);
      add(0, 1, 0, 1, 1, 20, 6, 1);
      add(0, 1, 0, 1, 0, 0, 6, 1);
      add(0, 1, 0, 1, 0, 0, 6, 1);
      add(0, 0, 1, 0, 0, 0, 6, 1);
      add(0, 1, 0, 0, 0, 0, 6, 1);
      // Push+pop while empty acts as push only.
      add(0, 1, 1, 1, 1, 28, 7, 1);
      add(0, 1, 0, 1, 0, 0, 7, 1);
      add(0, 1, 1, 0, 1, 30, 8, 1);
      // Reset with simultaneous event and pop clears everything.
      add(1, 1, 1, 1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 0, 1, 0);
      add(0, 1, 0, 1, 0, 0, 1, 0);

      reset_dut();
      check_all_zero("reset");

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].rd);
         check($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].v});
         check($sformatf("tbl%0d_count", i), {24'd0, count}, tbl[i].cnt);
         check($sformatf("tbl%0d_ovf", i), {31'd0, overflow}, {31'd0, tbl[i].ovf});
         if (tbl[i].v || tbl[i].r)
            check($sformatf("tbl%0d_ts", i), {16'd0, ts_out}, tbl[i].ts);
      end

      // w held high for three cycles.
      reset_dut();
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
      step(0, 1, 0, 0);
`ifdef SEQ_LOG_EDGE_EN
      check("hold3_count", {24'd0, count}, 32'd1);
      pop_check("hold3_e0", 0);
`else
      check("hold3_count", {24'd0, count}, 32'd3);
      pop_check("hold3_e0", 0);
      pop_check("hold3_e1", 1);
      pop_check("hold3_e2", 2);
`endif
      check("hold3_empty", {31'd0, valid}, 32'd0);

      // Overlapping 10010 detection feeding w.
      reset_dut();
      jbits = '{1, 0, 0, 1, 0, 0, 1, 0};
      hist = '0;
      for (int i = 0; i < 8; i++) begin
         hist = {hist[3:0], jbits[i]};
         wj = (hist == 5'b10010);
         step(0, 1, wj, 0);
      end
      check("mealy_count", {24'd0, count}, 32'd2);
      check("mealy_ovf", {31'd0, overflow}, 32'd0);
      pop_check("mealy_e0", 4);
      pop_check("mealy_e1", 7);
      check("mealy_empty", {31'd0, valid}, 32'd0);

      // 17 events with rd held high: narrow counter saturates at 15.
      reset_dut();
      for (int i = 0; i < 17; i++) begin
         step(0, 1, 1, 1);
         step(0, 1, 0, 1);
      end
      check("sat_count_s", {28'd0, count_s}, 32'd15);
      check("sat_count", {24'd0, count}, 32'd17);
      check("sat_ovf", {31'd0, overflow}, 32'd0);
      check("sat_valid", {31'd0, valid}, 32'd0);
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      check("wrap_valid_s", {31'd0, valid_s}, 32'd1);
      check("wrap_ts_s", {28'd0, ts_out_s}, 32'd2);
      check("wrap_ts", {16'd0, ts_out}, 32'd34);
      step(1, 1, 1, 1);
      check_all_zero("midrst");

      // Random traffic against the model.
      reset_dut();
      for (int i = 0; i < 3000; i++) begin
         rd_pct = ((i / 400) % 2 == 0) ? 20 : 70;
         step($urandom_range(0, 599) == 0,
              $urandom_range(0, 9) != 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) < rd_pct);
         compare_model(i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
